// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl_pkg.sv
// Shared types and constants for the JESD204 TPL DAC sync controller.
package ad_ip_jesd204_tpl_dac_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ARMED = 2'd1,
    ALIGN = 2'd2
  } sync_state_e;

  localparam int SYNC_COUNT_WIDTH = 8;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl_if.sv
// Control/status bundle between regmap/link side (master) and the sync controller (slave).
interface ad_ip_jesd204_tpl_dac_sync_ctrl_if;
  import ad_ip_jesd204_tpl_dac_pkg::*;

  logic                        link_ready;
  logic                        arm;
  logic                        disarm;
  logic                        manual_req;
  logic                        sync_in;
  logic                        data_en;
  logic                        dac_sync;
  logic                        armed;
  logic [SYNC_COUNT_WIDTH-1:0] sync_count;
  logic                        timeout;

  modport master (
    output link_ready, arm, disarm, manual_req, sync_in,
    input  data_en, dac_sync, armed, sync_count, timeout
  );

  modport slave (
    input  link_ready, arm, disarm, manual_req, sync_in,
    output data_en, dac_sync, armed, sync_count, timeout
  );

endinterface

// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl_edge.sv
// Sync trigger source: rising edge of the external sync level, or a software request.
module ad_ip_jesd204_tpl_dac_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  input  logic manual_req,
  output logic trigger
);

  logic sync_in_d;

  always_ff @(posedge clk) begin
    if (rst) sync_in_d <= 1'b0;
    else     sync_in_d <= sync_in;
  end

  assign trigger = (sync_in & ~sync_in_d) | manual_req;

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// TPL DAC start-up sequencer: arm -> wait trigger -> align delay -> release with dac_sync.
// Optional armed-timeout watchdog enabled by `define TPL_DAC_SYNC_TIMEOUT_EN.
module ad_ip_jesd204_tpl_dac_sync_ctrl
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int EXT_SYNC      = 1,
  parameter int SYNC_DELAY    = 0,
  parameter int DELAY_WIDTH   = 8,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  ad_ip_jesd204_tpl_dac_sync_ctrl_if.slave   sif
);

  localparam logic [DELAY_WIDTH-1:0] DLY_LOAD = DELAY_WIDTH'(SYNC_DELAY);

  sync_state_e                 state, state_nxt;
  logic [DELAY_WIDTH-1:0]      dly_cnt, dly_nxt;
  logic [SYNC_COUNT_WIDTH-1:0] sync_count_q;
  logic                        dac_sync_q, pulse_nxt;
  logic                        trigger, arm_ok, to_hit;

  // With EXT_SYNC=0 no arm is ever accepted, so the FSM never leaves RUN.
  assign arm_ok = sif.arm & ~sif.disarm & (EXT_SYNC != 0);

  ad_ip_jesd204_tpl_dac_sync_edge u_edge (
    .clk        (clk),
    .rst        (rst),
    .sync_in    (sif.sync_in),
    .manual_req (sif.manual_req),
    .trigger    (trigger)
  );

`ifdef TPL_DAC_SYNC_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] to_cnt;
  logic                     timeout_q;

  // Fires on the ARMED cycle whose increment would reach all-ones.
  assign to_hit = (state == ARMED) && (to_cnt == ~TIMEOUT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (state == RUN && arm_ok) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (state == ARMED) begin
      to_cnt <= to_cnt + TIMEOUT_WIDTH'(1);
      if (to_hit && !sif.disarm && !trigger) timeout_q <= 1'b1;
    end
  end

  assign sif.timeout = timeout_q;
`else
  assign to_hit      = (TIMEOUT_WIDTH < 0);  // never fires: ARMED waits indefinitely
  assign sif.timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    pulse_nxt = 1'b0;
    case (state)
      RUN: begin
        if (arm_ok) begin
          state_nxt = ARMED;
          dly_nxt   = DLY_LOAD;
        end
      end
      ARMED: begin
        if (sif.disarm) begin
          state_nxt = RUN;
        end else if (trigger) begin
          if (DLY_LOAD == '0) begin
            state_nxt = RUN;
            pulse_nxt = 1'b1;
          end else begin
            state_nxt = ALIGN;
          end
        end else if (to_hit) begin
          state_nxt = RUN;
        end
      end
      ALIGN: begin
        if (sif.disarm) begin
          state_nxt = RUN;
        end else if (sif.link_ready) begin
          dly_nxt = dly_cnt - DELAY_WIDTH'(1);
          if (dly_cnt == DELAY_WIDTH'(1)) begin
            state_nxt = RUN;
            pulse_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      dly_cnt      <= '0;
      dac_sync_q   <= 1'b0;
      sync_count_q <= '0;
    end else begin
      state      <= state_nxt;
      dly_cnt    <= dly_nxt;
      dac_sync_q <= pulse_nxt;
      if (pulse_nxt) sync_count_q <= sync_count_q + SYNC_COUNT_WIDTH'(1);
    end
  end

  assign sif.data_en    = (state == RUN);
  assign sif.armed      = (state != RUN);
  assign sif.dac_sync   = dac_sync_q;
  assign sif.sync_count = sync_count_q;

endmodule
